// File: rtl/dxi_window_gen.sv
// dxi_window_gen
// ----------------------------------------------------------------------------
// Upstream stage of the DXI 3x3 filter. Takes a raster-order 8-bit pixel
// stream, keeps the two previous lines in line buffers, and assembles every
// fully-interior 3x3 neighbourhood into a 72-bit DXI word. The kernel select
// sampled on the first pixel of a frame is carried alongside every window
// of that frame.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst            synchronous active-high reset
//   i_pix_valid      input pixel valid
//   i_pix_data[7:0]  input pixel, raster order, top-left first
//   o_pix_ready      stage can take a pixel this cycle
//   i_cfg_select[1:0] kernel select, latched on pixel (0,0)
//   o_dxi_valid      window valid
//   o_dxi_data[71:0] window, byte k = window row k/3, column k%3
//   i_dxi_ready      downstream ready
//   o_config_select[1:0] kernel select for the frame of the current window
//   o_dxi_last       marks the last window of a frame
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. A producer holding valid keeps its data stable until that edge.
// Pixel side: accept = i_pix_valid && o_pix_ready. Window side: o_dxi_valid
// with its data/last/select held until i_dxi_ready.
module dxi_window_gen #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_valid,
    input  logic [7:0]  i_pix_data,
    output logic        o_pix_ready,
    input  logic [1:0]  i_cfg_select,
    output logic        o_dxi_valid,
    output logic [71:0] o_dxi_data,
    input  logic        i_dxi_ready,
    output logic [1:0]  o_config_select,
    output logic        o_dxi_last
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [7:0]       lb0 [IMG_WIDTH];   // line row-1
    logic [7:0]       lb1 [IMG_WIDTH];   // line row-2
    logic [7:0]       win [9];           // index = wrow*3 + wcol
    logic [7:0]       win_next [9];
    logic [71:0]      win_packed;
    logic [1:0]       frame_cfg;

    logic accept;
    logic col_wrap;
    logic row_wrap;
    logic at_start;
    logic at_emit;

    // The output register can take a new window when it is empty or being
    // drained this cycle, so ready never looks at i_pix_valid.
    assign o_pix_ready = !i_rst && (!o_dxi_valid || i_dxi_ready);
    assign accept      = i_pix_valid && o_pix_ready;

    assign col_wrap = (col == COL_LAST);
    assign row_wrap = (row == ROW_LAST);
    assign at_start = (col == '0) && (row == '0);
    // Only interior positions have two valid columns to the left in this
    // row and two valid lines above in this frame, so stale line-buffer
    // content and border windows never reach the output.
    assign at_emit  = (row >= ROW_TWO) && (col >= COL_TWO);

    // Window after the shift that the current accept would perform.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_next[r*3 + 0] = win[r*3 + 1];
            win_next[r*3 + 1] = win[r*3 + 2];
        end
        win_next[2] = lb1[col];
        win_next[5] = lb0[col];
        win_next[8] = i_pix_data;
        for (int k = 0; k < 9; k++) begin
            win_packed[k*8 +: 8] = win_next[k];
        end
    end

    // Position counters and frame-level config.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col       <= '0;
            row       <= '0;
            frame_cfg <= '0;
        end else if (accept) begin
            if (at_start) begin
                frame_cfg <= i_cfg_select;
            end
            if (col_wrap) begin
                col <= '0;
                row <= row_wrap ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Line buffers and shift window carry data only; they are never read
    // into an emitted window before this frame has overwritten them.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= i_pix_data;
            for (int k = 0; k < 9; k++) begin
                win[k] <= win_next[k];
            end
        end
    end

    // Output register. A new window may replace one being drained in the
    // same cycle, which keeps valid high with no bubble.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_dxi_valid     <= 1'b0;
            o_dxi_data      <= '0;
            o_dxi_last      <= 1'b0;
            o_config_select <= '0;
        end else if (accept && at_emit) begin
            o_dxi_valid     <= 1'b1;
            o_dxi_data      <= win_packed;
            o_dxi_last      <= row_wrap && col_wrap;
            o_config_select <= frame_cfg;
        end else if (i_dxi_ready) begin
            o_dxi_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dxi_window_gen.sv
// Testbench for dxi_window_gen with a 4x4 image, pixel value = row*4+col.
// The reference keeps the accepted image in a 2-D array and cuts windows
// straight out of it; a per-cycle monitor checks handshake rules, latency,
// hold behaviour and every transferred window against that reference.
module tb_dxi_window_gen;

  localparam int W = 4;
  localparam int H = 4;
  localparam logic [71:0] FIRST_WIN = 72'h0A0908060504020100;
  localparam logic [71:0] LAST_WIN  = 72'h0F0E0D0B0A09070605;

  logic        i_clk;
  logic        i_rst;
  logic        i_pix_valid;
  logic [7:0]  i_pix_data;
  logic        o_pix_ready;
  logic [1:0]  i_cfg_select;
  logic        o_dxi_valid;
  logic [71:0] o_dxi_data;
  logic        i_dxi_ready;
  logic [1:0]  o_config_select;
  logic        o_dxi_last;

  dxi_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_pix_valid    (i_pix_valid),
    .i_pix_data     (i_pix_data),
    .o_pix_ready    (o_pix_ready),
    .i_cfg_select   (i_cfg_select),
    .o_dxi_valid    (o_dxi_valid),
    .o_dxi_data     (o_dxi_data),
    .i_dxi_ready    (i_dxi_ready),
    .o_config_select(o_config_select),
    .o_dxi_last     (o_dxi_last)
  );

  // ---------------- clock / reset ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // ---------------- scoreboard state ----------------
  int n_cmp;
  int n_bad;
  // entry = {cfg[1:0], last, data[71:0]}
  logic [74:0] exp_q[$];
  logic [74:0] got_q[$];
  logic [74:0] s1_q[$];

  logic [7:0]  img [H][W];
  int          mrow;
  int          mcol;
  logic [1:0]  mcfg;
  logic        pend;
  logic        prev_rst;
  logic        prev_hold;
  logic [71:0] prev_data;
  logic        prev_last;
  logic [1:0]  prev_cfg;

  logic        rnd_ready;
  logic        bp_arm;
  logic        bp_fired;
  int          bp_left;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input string why);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s", nm, why);
  endtask

  // ---------------- per-cycle monitor (negedge) ----------------
  task automatic monitor_step();
    logic        acc;
    logic [71:0] w;
    logic [74:0] e;
    if (prev_rst) begin
      chk("rst_valid", o_dxi_valid, 0);
      chk("rst_data", o_dxi_data, 0);
      chk("rst_last", o_dxi_last, 0);
      chk("rst_cfg", o_config_select, 0);
    end
    chk("pix_ready", o_pix_ready, !i_rst && (!o_dxi_valid || i_dxi_ready));
    if (!prev_rst) begin
      chk("valid", o_dxi_valid, pend || prev_hold);
      if (prev_hold) begin
        chk("hold_data", o_dxi_data, prev_data);
        chk("hold_last", o_dxi_last, prev_last);
        chk("hold_cfg", o_config_select, prev_cfg);
      end
    end
    if (o_dxi_valid && i_dxi_ready && !i_rst) begin
      got_q.push_back({o_config_select, o_dxi_last, o_dxi_data});
      if (exp_q.size() == 0) begin
        fail_now("window_extra", $sformatf("got %h expected no window", o_dxi_data));
      end else begin
        e = exp_q.pop_front();
        chk("win_data", o_dxi_data, e[71:0]);
        chk("win_last", o_dxi_last, e[72]);
        chk("win_cfg", o_config_select, e[74:73]);
      end
    end
    acc       = i_pix_valid && o_pix_ready;
    prev_hold = o_dxi_valid && !i_dxi_ready && !i_rst;
    prev_data = o_dxi_data;
    prev_last = o_dxi_last;
    prev_cfg  = o_config_select;
    pend      = 1'b0;
    if (i_rst) begin
      mrow = 0;
      mcol = 0;
      exp_q.delete();
    end else if (acc) begin
      img[mrow][mcol] = i_pix_data;
      if (mrow == 0 && mcol == 0) mcfg = i_cfg_select;
      if (mrow >= 2 && mcol >= 2) begin
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = img[mrow-2+k/3][mcol-2+k%3];
        exp_q.push_back({mcfg, (mrow == H-1 && mcol == W-1), w});
        pend = 1'b1;
      end
      mcol++;
      if (mcol == W) begin
        mcol = 0;
        mrow = (mrow == H-1) ? 0 : mrow + 1;
      end
    end
    prev_rst = i_rst;
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge i_clk);
      monitor_step();
    end
  endtask

  // ---------------- downstream ready driver ----------------
  task automatic ready_driver();
    forever begin
      @(posedge i_clk);
      #1;
      if (!bp_arm) bp_fired = 1'b0;
      else if (!bp_fired && o_dxi_valid) begin
        bp_fired = 1'b1;
        bp_left  = 5;
      end
      if (bp_left > 0) begin
        i_dxi_ready = 1'b0;
        bp_left--;
      end else if (rnd_ready) i_dxi_ready = ($urandom_range(0, 1) == 1);
      else i_dxi_ready = 1'b1;
    end
  endtask

  // ---------------- pixel driver ----------------
  task automatic send_frame(input logic [1:0] cfg0, input logic [1:0] cfg5,
                            input bit gapped, input int npix);
    bit acc;
    for (int p = 0; p < npix; p++) begin
      if (gapped) begin
        int g;
        g = $urandom_range(0, 2);
        for (int i = 0; i < g; i++) begin
          i_pix_valid = 1'b0;
          @(posedge i_clk);
          #1;
        end
      end
      i_pix_valid  = 1'b1;
      i_pix_data   = 8'(p);
      i_cfg_select = (p < 5) ? cfg0 : cfg5;
      acc = 1'b0;
      for (int c = 0; c < 500 && !acc; c++) begin
        @(negedge i_clk);
        acc = o_pix_ready;
        @(posedge i_clk);
        #1;
      end
      if (!acc) fail_now("accept_timeout", $sformatf("pixel %0d never accepted", p));
    end
    i_pix_valid = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || o_dxi_valid) && c < 500) begin
      @(negedge i_clk);
      c++;
    end
    if (c >= 500) fail_now("drain_timeout", $sformatf("%0d windows still pending", exp_q.size()));
    repeat (2) @(negedge i_clk);
    @(posedge i_clk);
    #1;
  endtask

  task automatic same_as_s1(input string nm, input int base);
    for (int i = 0; i < 4; i++) begin
      if (base + i < got_q.size()) chk(nm, got_q[base+i][71:0], s1_q[i][71:0]);
      else fail_now(nm, $sformatf("window %0d missing", base + i));
    end
  endtask

  task automatic bp_check();
    for (int c = 0; c < 400 && !bp_fired; c++) @(negedge i_clk);
    if (!bp_fired) fail_now("bp_timeout", "first window never seen");
    else begin
      for (int i = 0; i < 5; i++) begin
        chk("bp_pix_ready", o_pix_ready, 0);
        chk("bp_data", o_dxi_data, FIRST_WIN);
        if (i < 4) @(negedge i_clk);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_cmp = 0; n_bad = 0;
    mrow = 0; mcol = 0; mcfg = 2'b00;
    pend = 1'b0; prev_rst = 1'b0; prev_hold = 1'b0;
    prev_data = '0; prev_last = 1'b0; prev_cfg = 2'b00;
    rnd_ready = 1'b0; bp_arm = 1'b0; bp_fired = 1'b0; bp_left = 0;
    i_rst = 1'b1; i_pix_valid = 1'b0; i_pix_data = 8'h00;
    i_cfg_select = 2'b00; i_dxi_ready = 1'b1;
    fork
      monitor_loop();
      ready_driver();
    join_none
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // 1: single frame, ready high
    got_q.delete();
    send_frame(2'b10, 2'b10, 0, 16);
    drain();
    chk("s1_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("s1_first", got_q[0][71:0], FIRST_WIN);
      chk("s1_last_data", got_q[3][71:0], LAST_WIN);
      for (int i = 0; i < 4; i++) begin
        chk("s1_last_flag", got_q[i][72], i == 3);
        chk("s1_cfg", got_q[i][74:73], 2'b10);
      end
    end
    s1_q = got_q;

    // 2: backpressure after the first window
    got_q.delete();
    bp_arm = 1'b1;
    fork
      send_frame(2'b10, 2'b10, 0, 16);
      bp_check();
    join
    drain();
    bp_arm = 1'b0;
    chk("s2_count", got_q.size(), 4);
    same_as_s1("s2_order", 0);

    // 3: config latched at frame start only
    got_q.delete();
    send_frame(2'b10, 2'b01, 0, 16);
    send_frame(2'b01, 2'b01, 0, 16);
    drain();
    chk("s3_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      chk("s3_cfg", got_q[i][74:73], (i < 4) ? 2'b10 : 2'b01);

    // 4: reset mid-frame after 6 accepts
    got_q.delete();
    send_frame(2'b11, 2'b11, 0, 6);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    send_frame(2'b10, 2'b10, 0, 16);
    drain();
    chk("s4_count", got_q.size(), 4);
    if (got_q.size() > 0) chk("s4_first", got_q[0][71:0], FIRST_WIN);
    same_as_s1("s4_order", 0);

    // 5: back-to-back frames
    got_q.delete();
    send_frame(2'b10, 2'b10, 0, 16);
    send_frame(2'b10, 2'b10, 0, 16);
    drain();
    chk("s5_count", got_q.size(), 8);
    if (got_q.size() == 8) begin
      chk("s5_last4", got_q[3][72], 1);
      chk("s5_last8", got_q[7][72], 1);
      for (int i = 0; i < 4; i++) chk("s5_repeat", got_q[i+4][71:0], got_q[i][71:0]);
    end
    same_as_s1("s5_frame1", 0);

    // 6: gapped input, random ready
    got_q.delete();
    rnd_ready = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(2'b10, 2'b10, 1, 16);
    rnd_ready = 1'b0;
    drain();
    chk("s6_count", got_q.size(), 12);
    for (int f = 0; f < 3; f++) same_as_s1("s6_order", f * 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dxi_window_gen.md
# dxi_window_gen

Upstream stage of the DXI 3x3 filter (`dxi_top`). It accepts a raster-order 8-bit pixel stream over a valid/ready handshake. Two line buffers and a 3x3 shift window build every fully-interior 3x3 neighbourhood. Each window is emitted as a 72-bit DXI word together with the kernel select latched for the frame, ready to drive `i_dxi_data` / `config_select` of the filter.

## Interface
- `IMG_WIDTH`, default 8: pixels per line; minimum 3.
- `IMG_HEIGHT`, default 8: lines per frame; minimum 3.
- `i_clk`  in  1: clock; all logic on the rising edge.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_pix_valid`  in  1: input pixel valid.
- `i_pix_data`  in  8: input pixel, raster order (row-major, top-left first).
- `o_pix_ready`  out  1: the stage can accept a pixel this cycle.
- `i_cfg_select`  in  2: kernel select; sampled on the first pixel of each frame.
- `o_dxi_valid`  out  1: window valid.
- `o_dxi_data`  out  72: 3x3 window; byte k at `[k*8 +: 8]`.
- `i_dxi_ready`  in  1: downstream (filter) ready.
- `o_config_select`  out  2: kernel select for the current frame's windows.
- `o_dxi_last`  out  1: qualifies the last window of a frame.

## Operation
- **Accept rule.** A pixel is accepted when `i_pix_valid && o_pix_ready`.
  - `o_pix_ready = !i_rst && (!o_dxi_valid || i_dxi_ready)`. This is combinational from `i_dxi_ready`.
- **Counters.**
  - `col` counts 0..IMG_WIDTH-1 and `row` counts 0..IMG_HEIGHT-1.
  - Both advance only on accept.
  - `col` wraps to 0 and increments `row`.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0, and the next pixel starts a new frame.
- **Line buffers.** `lb0` holds row-1 and `lb1` holds row-2; each is IMG_WIDTH x 8. On accept at `col`:
  - `lb1[col] <= lb0[col]`
  - `lb0[col] <= pixel`
  - Contents are not reset.
- **Window.** The window is 3 columns x 3 rows of registers. On accept it shifts left one column, and the new right column becomes {`lb1[col]`, `lb0[col]`, pixel}.
- **Packing.** Emitted byte k maps to row k/3, column k%3 of the window:
  - byte 0 = (row-2, col-2)
  - byte 2 = (row-2, col)
  - byte 4 = (row-1, col-1), the centre
  - byte 8 = (row, col), the pixel just accepted
- **Emission.**
  - An accept with `row >= 2 && col >= 2` loads `o_dxi_data` with the post-shift window and sets `o_dxi_valid`.
  - Other accepts never set valid, so border and garbage windows are never emitted.
- **Last flag.** `o_dxi_last` is loaded 1 with the window at (IMG_HEIGHT-1, IMG_WIDTH-1), else 0.
- **Output hold.** `o_dxi_valid` clears on `i_dxi_ready` unless a new window loads in the same cycle. While valid and not ready, `o_dxi_data`, `o_dxi_last` and `o_config_select` hold and no pixel is accepted.
- **Config latch.**
  - An accept at (0,0) latches `i_cfg_select` into a frame register.
  - `o_config_select` is loaded from that register whenever a window loads, so it is stable per frame.
  - Mid-frame changes of `i_cfg_select` are ignored.
- **Throughput.** The block produces (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.

## Timing
- **Reset values:** `o_dxi_valid`=0, `o_dxi_data`=0, `o_dxi_last`=0, `o_config_select`=0, `col`=`row`=0, frame cfg register=0. `o_pix_ready`=0 while `i_rst`=1.
- **Latency:** the window appears on `o_dxi_valid` 1 cycle after the accept of its byte-8 pixel.
- **Full throughput:** with `i_dxi_ready` held 1, one pixel per cycle is sustained. Windows are back-to-back within a row, and there are no windows for columns 0..1.
- **Simultaneous events:**
  - Valid, ready, and a new window-producing accept in the same cycle: the new window replaces the old one, valid stays 1, and there is no bubble.
  - Reset asserted mid-frame: counters return to (0,0) and any pending window is dropped.
  - The first pixel after reset is treated as frame start and the cfg is latched. Stale line-buffer data is never emitted.
- **No combinational path from `i_pix_valid` to any output.**

## Test plan
All scenarios use IMG_WIDTH=IMG_HEIGHT=4, with pixel value = row*4+col.

1. **Single frame, ready=1, `i_cfg_select`=2'b10.**
   - Exactly 4 windows appear.
   - First window, 1 cycle after pixel 10: 72'h0A0908060504020100.
   - Last window: 72'h0F0E0D0B0A09070605 with `o_dxi_last`=1.
   - `o_config_select`=2'b10 on all 4 windows.
2. **Backpressure: `i_dxi_ready`=0 for 5 cycles after the first window.**
   - `o_pix_ready`=0 and `o_dxi_data` holds 72'h0A0908060504020100.
   - After ready returns, the remaining windows are in order with none lost or duplicated.
3. **Config latch: cfg=2'b10 at pixel 0, changed to 2'b01 at pixel 5.**
   - All frame-1 windows carry 2'b10.
   - Frame 2 with cfg=2'b01 at its pixel 0: all its windows carry 2'b01.
4. **Reset mid-frame: `i_rst` for 1 cycle after 6 accepts.**
   - Outputs return to reset values.
   - A full frame resent afterwards yields exactly the 4 windows of scenario 1, and the first equals 72'h0A0908060504020100.
5. **Back-to-back frames, pixel every cycle, ready=1.**
   - 8 windows total.
   - Windows 4 and 8 have `o_dxi_last`=1.
   - Frame-2 windows equal frame-1 windows.
6. **Gapped input: `i_pix_valid` toggled randomly, ready toggled randomly.** The window sequence is identical to scenario 1.
